// File: rtl/c1908_secded.sv
// Registered 16-bit SEC/DED decoder with c1908 pin names: Hamming(21,16) plus overall parity.
// Define C1908_SECDED_INREG_EN to add an input register stage (2-cycle latency).
module c1908_secded (
  input  logic clk,
  input  logic rst_n,
  input  logic N1,
  input  logic N4,
  input  logic N7,
  input  logic N10,
  input  logic N13,
  input  logic N16,
  input  logic N19,
  input  logic N22,
  input  logic N25,
  input  logic N28,
  input  logic N31,
  input  logic N34,
  input  logic N37,
  input  logic N40,
  input  logic N43,
  input  logic N46,
  input  logic N49,
  input  logic N53,
  input  logic N56,
  input  logic N60,
  input  logic N63,
  input  logic N66,
  input  logic N69,
  input  logic N72,
  input  logic N76,
  input  logic N79,
  input  logic N82,
  input  logic N85,
  input  logic N88,
  input  logic N91,
  input  logic N94,
  input  logic N99,
  input  logic N104,
  output logic N2753,
  output logic N2754,
  output logic N2755,
  output logic N2756,
  output logic N2762,
  output logic N2767,
  output logic N2768,
  output logic N2779,
  output logic N2780,
  output logic N2781,
  output logic N2782,
  output logic N2783,
  output logic N2784,
  output logic N2785,
  output logic N2786,
  output logic N2787,
  output logic N2886,
  output logic N2887,
  output logic N2888,
  output logic N2889,
  output logic N2890,
  output logic N2891,
  output logic N2892,
  output logic N2899,
  output logic N2811
);

  logic [15:0] dRaw;
  logic [5:0]  cRaw;
  logic        corrRaw;
  logic [9:0]  auxRaw;

  assign dRaw    = {N46, N43, N40, N37, N34, N31, N28, N25,
                    N22, N19, N16, N13, N10, N7,  N4,  N1};
  assign cRaw    = {N66, N63, N60, N56, N53, N49};
  assign corrRaw = N69;
  assign auxRaw  = {N104, N99, N94, N91, N88, N85, N82, N79, N76, N72};

  logic [15:0] dIn;
  logic [5:0]  cIn;
  logic        corrIn;
  logic [9:0]  auxIn;

`ifdef C1908_SECDED_INREG_EN
  logic [15:0] dIn_q;
  logic [5:0]  cIn_q;
  logic        corrIn_q;
  logic [9:0]  auxIn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dIn_q    <= '0;
      cIn_q    <= '0;
      corrIn_q <= 1'b0;
      auxIn_q  <= '0;
    end else begin
      dIn_q    <= dRaw;
      cIn_q    <= cRaw;
      corrIn_q <= corrRaw;
      auxIn_q  <= auxRaw;
    end
  end

  assign dIn    = dIn_q;
  assign cIn    = cIn_q;
  assign corrIn = corrIn_q;
  assign auxIn  = auxIn_q;
`else
  assign dIn    = dRaw;
  assign cIn    = cRaw;
  assign corrIn = corrRaw;
  assign auxIn  = auxRaw;
`endif

  // Codeword position of each data bit: the non-power-of-two slots 3..21 in order.
  function automatic logic [4:0] dataPos(input logic [3:0] idx);
    logic [4:0] pos;
    case (idx)
      4'd0:    pos = 5'd3;
      4'd1:    pos = 5'd5;
      4'd2:    pos = 5'd6;
      4'd3:    pos = 5'd7;
      4'd4:    pos = 5'd9;
      4'd5:    pos = 5'd10;
      4'd6:    pos = 5'd11;
      4'd7:    pos = 5'd12;
      4'd8:    pos = 5'd13;
      4'd9:    pos = 5'd14;
      4'd10:   pos = 5'd15;
      4'd11:   pos = 5'd17;
      4'd12:   pos = 5'd18;
      4'd13:   pos = 5'd19;
      4'd14:   pos = 5'd20;
      default: pos = 5'd21;
    endcase
    return pos;
  endfunction

  logic [4:0]  syn_d;
  logic [15:0] flipMask;

  // Syndrome is the XOR of the positions of all set data bits, folded with the check bits.
  always_comb begin
    syn_d    = cIn[4:0];
    flipMask = '0;
    for (int i = 0; i < 16; i++) begin
      if (dIn[i]) begin
        syn_d = syn_d ^ dataPos(4'(i));
      end
    end
    for (int i = 0; i < 16; i++) begin
      flipMask[i] = (syn_d == dataPos(4'(i)));
    end
  end

  logic        parity;
  logic        synZero;
  logic        synInRange;
  logic        sec_d;
  logic        ded_d;
  logic        noErr_d;
  logic        auxPar_d;
  logic [15:0] q_d;

  assign parity     = (^dIn) ^ (^cIn);
  assign synZero    = (syn_d == 5'd0);
  assign synInRange = (syn_d <= 5'd21);

  assign noErr_d  = synZero & ~parity;
  assign sec_d    = parity & (synZero | synInRange);
  assign ded_d    = ~synZero & (~parity | ~synInRange);
  assign auxPar_d = ^auxIn;

  // flipMask is empty for check-bit syndromes and out-of-range syndromes, so only data gets flipped.
  assign q_d = (corrIn && sec_d) ? (dIn ^ flipMask) : dIn;

  logic [15:0] q_q;
  logic [4:0]  syn_q;
  logic        sec_q;
  logic        ded_q;
  logic        noErr_q;
  logic        auxPar_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q      <= '0;
      syn_q    <= '0;
      sec_q    <= 1'b0;
      ded_q    <= 1'b0;
      noErr_q  <= 1'b0;
      auxPar_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      syn_q    <= syn_d;
      sec_q    <= sec_d;
      ded_q    <= ded_d;
      noErr_q  <= noErr_d;
      auxPar_q <= auxPar_d;
    end
  end

  assign N2753 = q_q[0];
  assign N2754 = q_q[1];
  assign N2755 = q_q[2];
  assign N2756 = q_q[3];
  assign N2762 = q_q[4];
  assign N2767 = q_q[5];
  assign N2768 = q_q[6];
  assign N2779 = q_q[7];
  assign N2780 = q_q[8];
  assign N2781 = q_q[9];
  assign N2782 = q_q[10];
  assign N2783 = q_q[11];
  assign N2784 = q_q[12];
  assign N2785 = q_q[13];
  assign N2786 = q_q[14];
  assign N2787 = q_q[15];

  assign N2886 = syn_q[0];
  assign N2887 = syn_q[1];
  assign N2888 = syn_q[2];
  assign N2889 = syn_q[3];
  assign N2890 = syn_q[4];

  assign N2891 = sec_q;
  assign N2892 = ded_q;
  assign N2899 = noErr_q;
  assign N2811 = auxPar_q;

endmodule

// File: tb/tb_c1908_secded.sv
// Self-checking bench for c1908_secded: directed vectors, random single/double errors, streaming and async reset.
module tb_c1908_secded;

`ifdef C1908_SECDED_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] d;
  logic [5:0]  c;
  logic        corr;
  logic [9:0]  aux;

  wire [15:0] qo;
  wire [4:0]  so;
  wire        secO;
  wire        dedO;
  wire        noErrO;
  wire        auxParO;
  wire [24:0] obs = {qo, so, secO, dedO, noErrO, auxParO};

  int nChecks = 0;
  int nFails  = 0;

  c1908_secded dut (
    .clk(clk), .rst_n(rst_n),
    .N1(d[0]), .N4(d[1]), .N7(d[2]), .N10(d[3]), .N13(d[4]), .N16(d[5]),
    .N19(d[6]), .N22(d[7]), .N25(d[8]), .N28(d[9]), .N31(d[10]), .N34(d[11]),
    .N37(d[12]), .N40(d[13]), .N43(d[14]), .N46(d[15]),
    .N49(c[0]), .N53(c[1]), .N56(c[2]), .N60(c[3]), .N63(c[4]), .N66(c[5]),
    .N69(corr),
    .N72(aux[0]), .N76(aux[1]), .N79(aux[2]), .N82(aux[3]), .N85(aux[4]),
    .N88(aux[5]), .N91(aux[6]), .N94(aux[7]), .N99(aux[8]), .N104(aux[9]),
    .N2753(qo[0]), .N2754(qo[1]), .N2755(qo[2]), .N2756(qo[3]),
    .N2762(qo[4]), .N2767(qo[5]), .N2768(qo[6]), .N2779(qo[7]),
    .N2780(qo[8]), .N2781(qo[9]), .N2782(qo[10]), .N2783(qo[11]),
    .N2784(qo[12]), .N2785(qo[13]), .N2786(qo[14]), .N2787(qo[15]),
    .N2886(so[0]), .N2887(so[1]), .N2888(so[2]), .N2889(so[3]), .N2890(so[4]),
    .N2891(secO), .N2892(dedO), .N2899(noErrO), .N2811(auxParO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: build the 21-position codeword, take the syndrome bit-by-bit, correct in place.
  function automatic logic [24:0] refModel(input logic [15:0] dv, input logic [5:0] cv,
                                           input logic ce, input logic [9:0] av);
    logic [21:0] cw;
    logic [4:0]  syn;
    logic [15:0] qv;
    logic        p, sec, ded, ne;
    int          j, k, s;
    cw = '0;
    qv = '0;
    j = 0;
    k = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        cw[pos] = cv[k];
        k++;
      end else begin
        cw[pos] = dv[j];
        j++;
      end
    end
    for (int b = 0; b < 5; b++) begin
      syn[b] = 1'b0;
      for (int pos = 1; pos <= 21; pos++) begin
        if (((pos >> b) & 1) == 1) syn[b] = syn[b] ^ cw[pos];
      end
    end
    s   = int'(syn);
    p   = (^dv) ^ (^cv);
    ne  = (s == 0) && !p;
    sec = p && (s <= 21);
    ded = (s != 0) && (!p || s > 21);
    if (sec && ce && s != 0 && (s & (s - 1)) != 0) cw[s] = ~cw[s];
    j = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        qv[j] = cw[pos];
        j++;
      end
    end
    return {qv, syn, sec, ded, ne, ^av};
  endfunction

  function automatic logic [5:0] encode(input logic [15:0] dv);
    logic [5:0] cv;
    int         pos;
    cv = '0;
    for (int b = 0; b < 5; b++) begin
      pos = 0;
      for (int p2 = 1; p2 <= 21; p2++) begin
        if ((p2 & (p2 - 1)) != 0) begin
          if (((p2 >> b) & 1) == 1) cv[b] = cv[b] ^ dv[pos];
          pos++;
        end
      end
    end
    cv[5] = (^dv) ^ (^cv[4:0]);
    return cv;
  endfunction

  task automatic applyVec(input logic [15:0] dv, input logic [5:0] cv,
                          input logic ce, input logic [9:0] av);
    d    = dv;
    c    = cv;
    corr = ce;
    aux  = av;
  endtask

  task automatic waitLatency();
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyVec(16'h0, 6'h0, 1'b1, 10'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (obs !== 25'h0) begin
      nFails++;
      $display("[TB] FAIL reset_hold: got %h expected %h", obs, 25'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitLatency();
    nChecks++;
    if (obs !== {16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL reset_first_zero_vector: got %h expected %h", obs,
               {16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    end
  endtask

  logic [15:0] dT [10];
  logic [5:0]  cT [10];
  logic        eT [10];
  logic [9:0]  aT [10];
  logic [24:0] xT [10];

  task automatic test_directed();
    dT = '{16'h0000, 16'h0001, 16'h0001, 16'h0003, 16'h0000,
           16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h8000};
    cT = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h04, 6'h00, 6'h1F, 6'h00, 6'h00};
    eT = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    aT = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h000,
           10'h000, 10'h001, 10'h000, 10'h000, 10'h000};
    xT = '{{16'h0000, 5'b00000, 4'b0010}, {16'h0000, 5'b00011, 4'b1000},
           {16'h0001, 5'b00011, 4'b1000}, {16'h0003, 5'b00110, 4'b0100},
           {16'h0000, 5'b00000, 4'b1000}, {16'h0000, 5'b00100, 4'b1000},
           {16'h0000, 5'b00000, 4'b0011}, {16'h0000, 5'b11111, 4'b0100},
           {16'h0000, 5'b10101, 4'b1000}, {16'h8000, 5'b10101, 4'b1000}};
    for (int i = 0; i < 10; i++) begin
      applyVec(dT[i], cT[i], eT[i], aT[i]);
      waitLatency();
      nChecks++;
      if (obs !== xT[i]) begin
        nFails++;
        $display("[TB] FAIL directed_%0d: got q=%h syn=%b flags=%b expected q=%h syn=%b flags=%b",
                 i, obs[24:9], obs[8:4], obs[3:0], xT[i][24:9], xT[i][8:4], xT[i][3:0]);
      end
    end
  endtask

  task automatic test_single_error();
    logic [15:0] dv, de;
    logic [5:0]  cv;
    logic        ce;
    logic [9:0]  av;
    logic [24:0] exp;
    int          b;
    for (int n = 0; n < 60; n++) begin
      dv = 16'($urandom);
      cv = encode(dv);
      de = dv;
      b  = int'($urandom_range(0, 21));
      if (b < 16) de[b] = ~de[b];
      else        cv[b - 16] = ~cv[b - 16];
      ce  = 1'($urandom);
      av  = 10'($urandom);
      exp = refModel(de, cv, ce, av);
      applyVec(de, cv, ce, av);
      waitLatency();
      nChecks++;
      if (obs !== exp) begin
        nFails++;
        $display("[TB] FAIL single_model bit=%0d: got %h expected %h", b, obs, exp);
      end
      nChecks++;
      if ({secO, dedO, noErrO} !== 3'b100 || (qo !== (ce ? dv : de))) begin
        nFails++;
        $display("[TB] FAIL single_property bit=%0d: got q=%h flags=%b expected q=%h flags=100",
                 b, qo, {secO, dedO, noErrO}, ce ? dv : de);
      end
    end
  endtask

  task automatic test_double_error();
    logic [15:0] dv;
    logic [5:0]  cv;
    logic [21:0] word;
    logic [24:0] exp;
    int          b1, b2;
    for (int n = 0; n < 40; n++) begin
      dv   = 16'($urandom);
      word = {encode(dv), dv};
      b1   = int'($urandom_range(0, 21));
      b2   = (b1 + int'($urandom_range(1, 21))) % 22;
      word[b1] = ~word[b1];
      word[b2] = ~word[b2];
      cv  = word[21:16];
      exp = refModel(word[15:0], cv, 1'b1, 10'h0);
      applyVec(word[15:0], cv, 1'b1, 10'h0);
      waitLatency();
      nChecks++;
      if (obs !== exp || {secO, dedO, noErrO} !== 3'b010 || qo !== word[15:0]) begin
        nFails++;
        $display("[TB] FAIL double bits=%0d,%0d: got %h expected %h (ded, uncorrected)",
                 b1, b2, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [24:0] expQ[$];
    logic [15:0] dv;
    logic [5:0]  cv;
    logic        ce;
    logic [9:0]  av;
    logic [24:0] exp;
    for (int n = 0; n < 50; n++) begin
      dv = 16'($urandom);
      cv = 6'($urandom);
      ce = 1'($urandom);
      av = 10'($urandom);
      applyVec(dv, cv, ce, av);
      expQ.push_back(refModel(dv, cv, ce, av));
      @(posedge clk);
      #1;
      if (expQ.size() == LAT) begin
        exp = expQ.pop_front();
        nChecks++;
        if (obs !== exp) begin
          nFails++;
          $display("[TB] FAIL back_to_back_%0d: got %h expected %h", n, obs, exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    applyVec(16'h0001, 6'h00, 1'b1, 10'h000);
    waitLatency();
    nChecks++;
    if (obs !== {16'h0000, 5'b00011, 4'b1000}) begin
      nFails++;
      $display("[TB] FAIL async_pre_sec: got %h expected %h", obs, {16'h0000, 5'b00011, 4'b1000});
    end
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (obs !== 25'h0) begin
      nFails++;
      $display("[TB] FAIL async_immediate_clear: got %h expected %h", obs, 25'h0);
    end
    applyVec(16'h0003, 6'h00, 1'b1, 10'h001);
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (obs !== 25'h0) begin
      nFails++;
      $display("[TB] FAIL async_held_clear: got %h expected %h", obs, 25'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    waitLatency();
    nChecks++;
    if (obs !== refModel(16'h0003, 6'h00, 1'b1, 10'h001)) begin
      nFails++;
      $display("[TB] FAIL async_release_load: got %h expected %h", obs,
               refModel(16'h0003, 6'h00, 1'b1, 10'h001));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyVec(16'h0, 6'h0, 1'b0, 10'h0);
    #3;
    nChecks++;
    if (obs !== 25'h0) begin
      nFails++;
      $display("[TB] FAIL power_on_reset: got %h expected %h", obs, 25'h0);
    end
    test_reset();
    test_directed();
    test_single_error();
    test_double_error();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
